blinker_pattern: RTL and testbench

BLINKER_PATTERN -- requirements
Module: blinker_pattern

---
 rtl/blinker_pkg.sv | 40 ++++
 rtl/blinker_step_div.sv | 41 ++++
 rtl/blinker_pattern.sv | 143 ++++++++++++++
 tb/tb_blinker_pattern.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/blinker_pkg.sv
// Shared types and constants for the LED pattern blinker.
// Mode encoding, FSM states and per-mode start patterns.
package blinker_pkg;

  typedef enum logic [1:0] {
    M_TOGGLE = 2'd0,
    M_ROTATE = 2'd1,
    M_BOUNCE = 2'd2,
    M_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TOGGLE   = 3'd1,
    S_ROTATE   = 3'd2,
    S_BOUNCE_L = 3'd3,
    S_BOUNCE_R = 3'd4,
    S_COUNT    = 3'd5
  } state_e;

  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] INIT_TOGGLE = '1;
  localparam logic [MAX_W-1:0] INIT_ROTATE = 64'd1;
  localparam logic [MAX_W-1:0] INIT_BOUNCE = 64'd1;
  localparam logic [MAX_W-1:0] INIT_COUNT  = '0;

  // Bounce always starts travelling left.
  function automatic state_e start_state(mode_e m);
    state_e s;
    unique case (m)
      M_TOGGLE: s = S_TOGGLE;
      M_ROTATE: s = S_ROTATE;
      M_BOUNCE: s = S_BOUNCE_L;
      M_COUNT:  s = S_COUNT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/blinker_step_div.sv
// Step prescaler: divides upstream tick pulses by DIV.
// Emits a registered one-cycle step pulse; cleared while disabled.
module blinker_step_div #(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_tick,
  output logic o_step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_step;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (i_tick) begin
        if (r_cnt == LAST) begin
          r_cnt  <= '0;
          r_step <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/blinker_pattern.sv
// LED pattern generator: toggle, rotate, bounce and count modes.
// Mode changes are buffered and take effect on a pattern step.
module blinker_pattern
  import blinker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 10
) (
  input  logic             system1000,
  input  logic             system1000_rst,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             mode_vld_i,
  output logic             mode_rdy_o,
  output logic [1:0]       cur_mode_o,
  output logic             step_o,
  output logic [WIDTH-1:0] led_o
);

  state_e           r_state;
  logic [WIDTH-1:0] r_led;
  mode_e            r_mode;
  logic             r_pv;
  mode_e            r_pm;
  logic             r_rdy;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_led_nxt;
  mode_e            w_mode_nxt;
  logic             w_pv_nxt;
  mode_e            w_pm_nxt;

  logic             w_step;
  logic             w_accept;
  mode_e            w_req;
  mode_e            w_load_mode;
  logic [WIDTH-1:0] w_init;

  blinker_step_div #(
    .DIV(DIV)
  ) u_div (
    .i_clk  (system1000),
    .i_rst  (system1000_rst),
    .i_en   (en_i),
    .i_tick (tick_i),
    .o_step (w_step)
  );

  assign w_accept = mode_vld_i & r_rdy;
  assign w_req    = mode_e'(mode_i);

  // Leaving IDLE picks up a same-cycle request; otherwise the pending one.
  always_comb begin
    w_load_mode = r_pm;
    if (r_state == S_IDLE)
      w_load_mode = w_accept ? w_req : r_mode;
  end

  always_comb begin
    w_init = '0;
    unique case (w_load_mode)
      M_TOGGLE: w_init = WIDTH'(INIT_TOGGLE);
      M_ROTATE: w_init = WIDTH'(INIT_ROTATE);
      M_BOUNCE: w_init = WIDTH'(INIT_BOUNCE);
      M_COUNT:  w_init = WIDTH'(INIT_COUNT);
    endcase
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      r_state <= S_IDLE;
      r_led   <= '0;
      r_mode  <= M_TOGGLE;
      r_pv    <= 1'b0;
      r_pm    <= M_TOGGLE;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_mode  <= w_mode_nxt;
      r_pv    <= w_pv_nxt;
      r_pm    <= w_pm_nxt;
      r_rdy   <= ~w_pv_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_mode_nxt  = r_mode;
    w_pv_nxt    = r_pv;
    w_pm_nxt    = r_pm;

    if (!en_i) begin
      w_state_nxt = S_IDLE;
      w_led_nxt   = '0;
    end else if (r_state == S_IDLE) begin
      w_state_nxt = start_state(w_load_mode);
      w_led_nxt   = w_init;
    end else if (w_step) begin
      if (r_pv) begin
        w_mode_nxt  = r_pm;
        w_pv_nxt    = 1'b0;
        w_state_nxt = start_state(r_pm);
        w_led_nxt   = w_init;
      end else begin
        unique case (r_state)
          S_TOGGLE: w_led_nxt = ~r_led;
          S_ROTATE: w_led_nxt = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
          S_BOUNCE_L: begin
            w_led_nxt = r_led << 1;
            if (r_led[WIDTH-2]) w_state_nxt = S_BOUNCE_R;
          end
          S_BOUNCE_R: begin
            w_led_nxt = r_led >> 1;
            if (r_led[1]) w_state_nxt = S_BOUNCE_L;
          end
          S_COUNT: w_led_nxt = r_led + WIDTH'(1);
          default: w_led_nxt = r_led;
        endcase
      end
    end

    // In IDLE a request is the mode; when running it waits for a step.
    if (w_accept) begin
      if (r_state == S_IDLE) begin
        w_mode_nxt = w_req;
      end else begin
        w_pv_nxt = 1'b1;
        w_pm_nxt = w_req;
      end
    end
  end

  always_comb begin
    mode_rdy_o = r_rdy;
    cur_mode_o = r_mode;
    step_o     = w_step;
    led_o      = r_led;
  end

endmodule

// File: tb/tb_blinker_pattern.sv
// Directed bench for blinker_pattern (WIDTH=8, DIV=3).
// Expected LED values are queued on stimulus and popped on each update.
module tb_blinker_pattern;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         en;
  logic [1:0]   mode;
  logic         vld;
  logic         rdy;
  logic [1:0]   cur;
  logic         step;
  logic [W-1:0] led;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_led;
  logic         m_left;

  always #5 clk = ~clk;

  blinker_pattern #(
    .WIDTH(W),
    .DIV  (D)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .tick_i         (tick),
    .en_i           (en),
    .mode_i         (mode),
    .mode_vld_i     (vld),
    .mode_rdy_o     (rdy),
    .cur_mode_o     (cur),
    .step_o         (step),
    .led_o          (led)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_led(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %0h", tag, led);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'd0, led}, {24'd0, e});
    end
  endtask

  // Ends on the negedge where step_o is high.
  task automatic do_ticks(input string tag);
    for (int i = 0; i < D; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk({tag, "_stp"}, {31'd0, step}, {31'd0, (i == D - 1)});
      if (i != D - 1) @(negedge clk);
    end
  endtask

  task automatic do_step(input string tag);
    do_ticks(tag);
    @(negedge clk);
    chk_led(tag);
    chk({tag, "_stp0"}, {31'd0, step}, 32'd0);
  endtask

  task automatic req(input logic [1:0] m);
    mode = m;
    vld  = 1'b1;
    @(negedge clk);
    vld  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    en   = 1'b0;
    mode = 2'd0;
    vld  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_cur", {30'd0, cur}, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_led", {24'd0, led}, 32'd0);

    // Toggle from reset: FF -> 00 -> FF
    en = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'hFF);
    chk_led("tog_init");
    exp_q.push_back(8'h00);
    do_step("tog1");
    exp_q.push_back(8'hFF);
    do_step("tog2");

    // Bounce selected in IDLE
    en = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'h00);
    chk_led("dis_led");
    req(2'd2);
    chk("idle_cur", {30'd0, cur}, 32'd2);
    chk("idle_rdy", {31'd0, rdy}, 32'd1);
    en = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h01);
    chk_led("bnc_init");
    chk("bnc_cur", {30'd0, cur}, 32'd2);
    m_led  = 8'h01;
    m_left = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (m_left) m_led = m_led << 1;
      else        m_led = m_led >> 1;
      if (m_led[W-1]) m_left = 1'b0;
      if (m_led[0])   m_left = 1'b1;
      exp_q.push_back(m_led);
      do_step("bnc");
      chk("bnc_hot", $countones(led), 32'd1);
    end

    // Drop enable with prescaler part-way
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    en   = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'h00);
    chk_led("drop_led");
    chk("drop_cur", {30'd0, cur}, 32'd2);
    en = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h01);
    chk_led("reen_led");
    exp_q.push_back(8'h02);
    do_step("reen_stp");

    // Switch to rotate, walk to 80
    req(2'd1);
    chk("rot_rdy0", {31'd0, rdy}, 32'd0);
    chk("rot_cur_old", {30'd0, cur}, 32'd2);
    exp_q.push_back(8'h01);
    do_step("rot_load");
    chk("rot_cur", {30'd0, cur}, 32'd1);
    chk("rot_rdy1", {31'd0, rdy}, 32'd1);
    m_led = 8'h01;
    for (int k = 0; k < 7; k++) begin
      m_led = {m_led[W-2:0], m_led[W-1]};
      exp_q.push_back(m_led);
      do_step("rot");
    end

    // Count requested at 80
    req(2'd3);
    chk("cnt_rdy0", {31'd0, rdy}, 32'd0);
    exp_q.push_back(8'h00);
    do_step("cnt_load");
    chk("cnt_cur", {30'd0, cur}, 32'd3);
    chk("cnt_rdy1", {31'd0, rdy}, 32'd1);
    exp_q.push_back(8'h01);
    do_step("cnt1");

    // Request accepted on the step edge applies one step later
    do_ticks("same");
    mode = 2'd0;
    vld  = 1'b1;
    @(negedge clk);
    vld  = 1'b0;
    exp_q.push_back(8'h02);
    chk_led("same_old");
    chk("same_cur", {30'd0, cur}, 32'd3);
    chk("same_rdy", {31'd0, rdy}, 32'd0);
    exp_q.push_back(8'hFF);
    do_step("same_new");
    chk("same_cur2", {30'd0, cur}, 32'd0);

    // Same mode reload: FF stays FF instead of toggling
    req(2'd0);
    exp_q.push_back(8'hFF);
    do_step("reload");

    // Reset overrides pending and a live handshake
    req(2'd1);
    chk("pend_rdy", {31'd0, rdy}, 32'd0);
    rst  = 1'b1;
    mode = 2'd3;
    vld  = 1'b1;
    @(negedge clk);
    chk("mrst_rdy", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    vld = 1'b0;
    chk("mrst_led", {24'd0, led}, 32'd0);
    chk("mrst_step", {31'd0, step}, 32'd0);
    chk("mrst_cur", {30'd0, cur}, 32'd0);
    chk("mrst_rdy2", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    exp_q.push_back(8'hFF);
    chk_led("post_init");
    exp_q.push_back(8'h00);
    do_step("post_tog");
    chk("post_cur", {30'd0, cur}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
